dpga_config_loader: RTL and testbench
=====================================

Name: dpga_config_loader

Overview:
- Sequencer that streams configuration words from a host into the DPGA serial configuration chain, which is a `shift_register`-style sdi chain.
- Accepts parallel words over a valid/ready handshake and serializes each one MSB-first onto `sdi`, with a per-bit shift enable.
- After the last word, pulses `latch` to commit the chain contents, then pulses `done`.
- Sits between the host/config bus and the configuration shift chain.

Parameters:
- WORD, 8: bits per configuration word; equals the shift-chain segment width.
- NWORDS, 4: words per full configuration frame; must be ≥ 1.
- BCNT_W, $clog2(WORD): bit counter width (local).
- WCNT_W, $clog2(NWORDS)+1: word counter width (local).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a frame load; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- cfg_data  in  WORD  configuration word from host.
- cfg_valid  in  1  host has a word on cfg_data.
- cfg_ready  out  1  loader will accept cfg_data this cycle.
- sdi  out  1  serial data to the chain; valid whenever shift_en=1.
- shift_en  out  1  chain shifts in sdi on this clk edge.
- latch  out  1  one-cycle commit pulse to the configuration plane.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after a completed frame.
- aborted  out  1  one-cycle pulse when an abort is taken.
- words_loaded  out  WCNT_W  words fully shifted in the current/last frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: cfg_ready, sdi, shift_en, latch, busy, done, aborted, words_loaded.
  - Internal shift buffer and counters cleared.
- FSM states: IDLE, LOAD, SHIFT, LATCH, DONE.
- IDLE:
  - start=1 → LOAD next cycle; words_loaded cleared to 0 on that edge.
  - start while busy is ignored (no queuing).
- LOAD:
  - cfg_ready=1 (registered; high for the whole state).
  - When cfg_valid & cfg_ready: capture cfg_data into the buffer, clear the bit counter, go to SHIFT.
  - No transfer: stay in LOAD indefinitely (no timeout).
- SHIFT:
  - shift_en=1 and sdi=buffer[WORD-1-bitcnt] every cycle, for exactly WORD consecutive cycles. MSB is the first bit out.
  - cfg_ready=0 throughout.
  - On the cycle bitcnt=WORD-1, words_loaded increments.
  - If words_loaded+1 = NWORDS → LATCH; otherwise → LOAD.
- LATCH: latch=1 for exactly one cycle; shift_en=0; → DONE.
- DONE: done=1 for exactly one cycle; busy=0 in this state; → IDLE.
- Timing per word: 1 handshake cycle + WORD shift cycles.
  - Minimum frame length from start to done = 1 + NWORDS×(WORD+1) + 2 cycles, with cfg_valid held high.
- sdi is held at 0 whenever shift_en=0.
- abort=1 in any busy state (LOAD, SHIFT, LATCH):
  - Next state IDLE; aborted=1 for one cycle.
  - latch and done are never asserted for that frame.
  - words_loaded keeps its value for host diagnostics.
  - A partially shifted word is discarded.
- abort in IDLE or DONE has no effect (aborted stays 0).
- abort and start in the same IDLE cycle: start wins (abort ignored in IDLE).
- abort and a handshake in the same LOAD cycle: abort wins; the word is not consumed.
  - The host must treat that transfer as not accepted: cfg_ready falls next cycle.
- Reset mid-frame: immediate return to IDLE with reset values; no latch pulse.
- NWORDS=1: LOAD → SHIFT → LATCH, with no second LOAD.

Decomposition:
- Shared package dpga_cfg_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, LATCH, DONE);
  - default WORD/NWORDS constants;
  - MSB_FIRST=1 constant, documenting chain bit order for other DPGA blocks.
- One natural sub-module: cfg_serializer, containing the buffer, bit counter, sdi/shift_en generation, and a last_bit flag.
- The top-level FSM, word counter and handshake stay in dpga_config_loader.

Test Plan (WORD=8, NWORDS=2, cfg_valid held high unless stated):
- Reset: reset=0 asserted between clock edges → all outputs 0 immediately. Release + no start → outputs stay 0 for 20 cycles.
- Full frame, words 0xA5 then 0x3C:
  - sdi sequence under shift_en = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - latch one cycle; done on the next cycle; done at cycle 1+2×9+2=21 after the start edge.
  - words_loaded=2; a model shift_register reads 0x3C with 0xA5 upstream.
- Host stall: cfg_valid low for 5 cycles in LOAD → cfg_ready stays 1, shift_en stays 0. Then valid with 0xFF → 8 cycles of sdi=1.
- Abort during SHIFT (3rd bit of word 2) → aborted pulse; IDLE next cycle; latch and done never assert; words_loaded=1.
- Abort and handshake in the same LOAD cycle → word not consumed; no shift_en. A following start reloads from word 0.
- Start pulses while busy → ignored; exactly one done per frame.
- Reset asserted mid-SHIFT → outputs cleared asynchronously; no latch.

Source files
------------

// File: rtl/dpga_cfg_pkg.sv
// Shared definitions for the DPGA configuration loader and the blocks that talk
// to the configuration shift chain.
package dpga_cfg_pkg;

   localparam int CFG_WORD_DEF   = 8;
   localparam int CFG_NWORDS_DEF = 4;

   // Words enter the chain most-significant bit first.
   localparam bit MSB_FIRST = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4
   } cfg_state_e;

endpackage

// File: rtl/dpga_config_loader_serializer.sv
// Parallel-to-serial stage: holds one configuration word and emits it MSB-first
// with a registered sdi/shift_en pair, flagging the final bit of the word.
module cfg_serializer
   import dpga_cfg_pkg::*;
#(
   parameter  int WORD   = CFG_WORD_DEF,
   localparam int BCNT_W = (WORD > 1) ? $clog2(WORD) : 1
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clear,
   input  logic            i_load,
   input  logic [WORD-1:0] i_data,
   output logic            o_sdi,
   output logic            o_shift_en,
   output logic            o_last_bit
);

   logic [WORD-1:0]   r_buf;
   logic [BCNT_W-1:0] r_bitcnt;
   logic              r_sdi;
   logic              r_shift_en;
   logic              w_last_bit;

   assign w_last_bit = r_shift_en && (r_bitcnt == BCNT_W'(WORD - 1));

   // Buffer shifts left so its MSB is always the next bit to present on sdi.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf      <= '0;
         r_bitcnt   <= '0;
         r_sdi      <= 1'b0;
         r_shift_en <= 1'b0;
      end else if (i_clear) begin
         r_buf      <= '0;
         r_bitcnt   <= '0;
         r_sdi      <= 1'b0;
         r_shift_en <= 1'b0;
      end else if (i_load) begin
         r_buf      <= {i_data[WORD-2:0], 1'b0};
         r_bitcnt   <= '0;
         r_sdi      <= i_data[WORD-1];
         r_shift_en <= 1'b1;
      end else if (r_shift_en) begin
         if (w_last_bit) begin
            r_buf      <= '0;
            r_bitcnt   <= '0;
            r_sdi      <= 1'b0;
            r_shift_en <= 1'b0;
         end else begin
            r_buf      <= {r_buf[WORD-2:0], 1'b0};
            r_bitcnt   <= r_bitcnt + BCNT_W'(1);
            r_sdi      <= r_buf[WORD-1];
            r_shift_en <= 1'b1;
         end
      end else begin
         r_buf      <= r_buf;
         r_bitcnt   <= r_bitcnt;
         r_sdi      <= r_sdi;
         r_shift_en <= r_shift_en;
      end
   end

   assign o_sdi      = r_sdi;
   assign o_shift_en = r_shift_en;
   assign o_last_bit = w_last_bit;

endmodule

// File: rtl/dpga_config_loader.sv
// Frame sequencer: accepts NWORDS host words over valid/ready, streams each into
// the configuration chain, then commits with latch and reports done.
module dpga_config_loader
   import dpga_cfg_pkg::*;
#(
   parameter  int WORD   = CFG_WORD_DEF,
   parameter  int NWORDS = CFG_NWORDS_DEF,
   localparam int WCNT_W = $clog2(NWORDS) + 1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD-1:0]   cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              sdi,
   output logic              shift_en,
   output logic              latch,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [WCNT_W-1:0] words_loaded
);

   cfg_state_e        r_state;
   cfg_state_e        w_next;
   logic              w_abort_take;
   logic              w_capture;
   logic              w_last_bit;
   logic              r_cfg_ready;
   logic              r_busy;
   logic              r_latch;
   logic              r_done;
   logic              r_aborted;
   logic [WCNT_W-1:0] r_words;

   cfg_serializer #(.WORD(WORD)) u_ser (
      .clk        (clk),
      .rst_n      (reset),
      .i_clear    (w_abort_take),
      .i_load     (w_capture),
      .i_data     (cfg_data),
      .o_sdi      (sdi),
      .o_shift_en (shift_en),
      .o_last_bit (w_last_bit)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state; abort beats a same-cycle handshake so the word is never consumed.
   always_comb begin
      w_next       = r_state;
      w_abort_take = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_LOAD;
            else       w_next = ST_IDLE;
         end
         ST_LOAD: begin
            if (abort) begin
               w_abort_take = 1'b1;
               w_next       = ST_IDLE;
            end else if (cfg_valid && r_cfg_ready) begin
               w_capture = 1'b1;
               w_next    = ST_SHIFT;
            end else begin
               w_next = ST_LOAD;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               w_abort_take = 1'b1;
               w_next       = ST_IDLE;
            end else if (w_last_bit) begin
               if ((r_words + WCNT_W'(1)) == WCNT_W'(NWORDS)) w_next = ST_LATCH;
               else                                           w_next = ST_LOAD;
            end else begin
               w_next = ST_SHIFT;
            end
         end
         ST_LATCH: begin
            if (abort) begin
               w_abort_take = 1'b1;
               w_next       = ST_IDLE;
            end else begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_latch     <= 1'b0;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
         r_words     <= '0;
      end else begin
         r_cfg_ready <= (w_next == ST_LOAD);
         r_busy      <= (w_next == ST_LOAD) || (w_next == ST_SHIFT) || (w_next == ST_LATCH);
         r_latch     <= (w_next == ST_LATCH);
         r_done      <= (w_next == ST_DONE);
         r_aborted   <= w_abort_take;
         if ((r_state == ST_IDLE) && start) begin
            r_words <= '0;
         end else if ((r_state == ST_SHIFT) && w_last_bit && !abort) begin
            r_words <= r_words + WCNT_W'(1);
         end else begin
            r_words <= r_words;
         end
      end
   end

   assign cfg_ready    = r_cfg_ready;
   assign busy         = r_busy;
   assign latch        = r_latch;
   assign done         = r_done;
   assign aborted      = r_aborted;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_dpga_config_loader.sv
// Self-checking bench for dpga_config_loader (WORD=8, NWORDS=2) with an sdi
// scoreboard and a model of the downstream shift chain.
module tb_dpga_config_loader;

   localparam int WORD   = 8;
   localparam int NWORDS = 2;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [7:0] cfg_data;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       sdi;
   logic       shift_en;
   logic       latch;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [1:0] words_loaded;

   int         n_cmp;
   int         n_err;
   int         n_done;
   int         n_latch;
   logic       sb_q[$];
   logic [15:0] chain;

   dpga_config_loader #(.WORD(WORD), .NWORDS(NWORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .cfg_data     (cfg_data),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .sdi          (sdi),
      .shift_en     (shift_en),
      .latch        (latch),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] all_outs();
      return {cfg_ready, sdi, shift_en, latch, busy, done, aborted, words_loaded};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of the downstream chain: shifts sdi in at the LSB on each enabled edge.
   always @(posedge clk) begin
      if (reset && shift_en) chain <= {chain[14:0], sdi};
   end

   // Scoreboard consumer and pulse counters.
   always @(negedge clk) begin
      if (reset) begin
         if (shift_en) begin
            if (sb_q.size() == 0) chk("sdi_unexpected_shift", 32'd1, 32'd0);
            else                  chk("sdi_bit", {31'd0, sdi}, {31'd0, sb_q.pop_front()});
         end else begin
            chk("sdi_idle_zero", {31'd0, sdi}, 32'd0);
         end
         if (done)  n_done++;
         if (latch) n_latch++;
      end
   end

   task automatic push_word(input logic [7:0] w);
      logic [7:0] v;
      v = w;
      for (int b = 7; b >= 0; b--) sb_q.push_back(v[b]);
   endtask

   // Host model: cycle 1 is the IDLE cycle in which start is high.
   task automatic frame(input logic [7:0] w0, input logic [7:0] w1, input int stall_n,
                        input int abort_cyc, input bit spam,
                        output int end_cyc, output int latch_cyc, output bit was_abort);
      int idx;
      int stall;
      idx = 0;
      stall = stall_n;
      end_cyc = -1;
      latch_cyc = -1;
      was_abort = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         abort = (c == abort_cyc);
         if (spam && (c == 6 || c == 15)) start = 1'b1;
         if (cfg_ready && idx < 2) begin
            if (stall > 0) begin
               cfg_valid = 1'b0;
               stall--;
               chk("stall_ready", {31'd0, cfg_ready}, 32'd1);
               chk("stall_no_shift", {31'd0, shift_en}, 32'd0);
            end else begin
               cfg_valid = 1'b1;
               cfg_data  = (idx == 0) ? w0 : w1;
               if (!abort) begin
                  push_word(cfg_data);
                  idx++;
               end
            end
         end else begin
            cfg_valid = 1'b0;
         end
         tick();
         start = 1'b0;
         if (latch) latch_cyc = c + 1;
         if (done) begin
            end_cyc = c + 1;
            break;
         end
         if (aborted) begin
            end_cyc = c + 1;
            was_abort = 1'b1;
            break;
         end
      end
      abort = 1'b0;
      cfg_valid = 1'b0;
      start = 1'b0;
      if (end_cyc < 0) chk("frame_timeout", 32'd0, 32'd1);
   endtask

   int  e_cyc;
   int  l_cyc;
   bit  ab;
   int  d0;
   int  l0;

   initial begin
      n_cmp = 0; n_err = 0; n_done = 0; n_latch = 0;
      chain = 16'h0000;
      start = 1'b0; abort = 1'b0; cfg_data = 8'h00; cfg_valid = 1'b0;
      reset = 1'b0;
      #23;
      chk("reset_outputs", {23'd0, all_outs()}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outputs", {23'd0, all_outs()}, 32'd0);
      end

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_in_idle", {31'd0, aborted}, 32'd0);

      // Full frame 0xA5, 0x3C.
      d0 = n_done; l0 = n_latch;
      frame(8'hA5, 8'h3C, 0, -1, 1'b0, e_cyc, l_cyc, ab);
      chk("frame1_done_cycle", e_cyc, 32'd21);
      chk("frame1_latch_cycle", l_cyc, 32'd20);
      chk("frame1_busy_in_done", {31'd0, busy}, 32'd0);
      chk("frame1_words", {30'd0, words_loaded}, 32'd2);
      tick(); tick(); tick();
      chk("frame1_chain", {16'd0, chain}, 32'h0000A53C);
      chk("frame1_done_count", n_done - d0, 32'd1);
      chk("frame1_latch_count", n_latch - l0, 32'd1);
      chk("frame1_sb_empty", sb_q.size(), 32'd0);

      // Host stall then 0xFF.
      frame(8'hFF, 8'h00, 5, -1, 1'b0, e_cyc, l_cyc, ab);
      chk("stall_done_cycle", e_cyc, 32'd26);
      tick(); tick();
      chk("stall_chain", {16'd0, chain}, 32'h0000FF00);
      chk("stall_sb_empty", sb_q.size(), 32'd0);

      // Abort on the third bit of the second word.
      d0 = n_done; l0 = n_latch;
      frame(8'h5A, 8'hC6, 0, 14, 1'b0, e_cyc, l_cyc, ab);
      chk("abort_shift_taken", {31'd0, ab}, 32'd1);
      chk("abort_shift_cycle", e_cyc, 32'd15);
      chk("abort_shift_busy", {31'd0, busy}, 32'd0);
      chk("abort_shift_sen", {31'd0, shift_en}, 32'd0);
      chk("abort_shift_words", {30'd0, words_loaded}, 32'd1);
      chk("abort_shift_left", sb_q.size(), 32'd5);
      sb_q.delete();
      tick();
      chk("abort_pulse_len", {31'd0, aborted}, 32'd0);
      tick(); tick();
      chk("abort_shift_no_done", n_done - d0, 32'd0);
      chk("abort_shift_no_latch", n_latch - l0, 32'd0);

      // Abort together with the first handshake.
      frame(8'h11, 8'h22, 0, 2, 1'b0, e_cyc, l_cyc, ab);
      chk("abort_hs_taken", {31'd0, ab}, 32'd1);
      chk("abort_hs_cycle", e_cyc, 32'd3);
      chk("abort_hs_sen", {31'd0, shift_en}, 32'd0);
      chk("abort_hs_ready", {31'd0, cfg_ready}, 32'd0);
      chk("abort_hs_words", {30'd0, words_loaded}, 32'd0);
      chk("abort_hs_sb_empty", sb_q.size(), 32'd0);
      tick();
      frame(8'h81, 8'h7E, 0, -1, 1'b0, e_cyc, l_cyc, ab);
      chk("reload_done_cycle", e_cyc, 32'd21);
      tick(); tick();
      chk("reload_chain", {16'd0, chain}, 32'h0000817E);

      // Start pulses while busy are ignored.
      d0 = n_done;
      frame(8'h96, 8'h69, 0, -1, 1'b1, e_cyc, l_cyc, ab);
      chk("spam_done_cycle", e_cyc, 32'd21);
      for (int i = 0; i < 6; i++) tick();
      chk("spam_idle_busy", {31'd0, busy}, 32'd0);
      chk("spam_done_count", n_done - d0, 32'd1);
      chk("spam_chain", {16'd0, chain}, 32'h00009669);

      // Reset in the middle of shifting.
      l0 = n_latch;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data = 8'hC3;
      push_word(cfg_data);
      tick();
      cfg_valid = 1'b0;
      tick(); tick();
      chk("midrst_shifting", {31'd0, shift_en}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_outputs", {23'd0, all_outs()}, 32'd0);
      sb_q.delete();
      tick();
      #2;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("midrst_idle", {23'd0, all_outs()}, 32'd0);
      chk("midrst_no_latch", n_latch - l0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
